// File: rtl/ir_buffer.sv
// Instruction register / prefetch FIFO between fetch and decode, head pre-split into MIPS fields.
// Optional PC tracking per entry is enabled with the IR_PC_TRACK_EN macro.
module ir_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4,
  parameter int unsigned PC_W   = 32
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       flush,
  input  logic [DATA_W-1:0]          instr_i,
  input  logic                       in_valid,
  output logic                       in_ready,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_W-1:0]          instr_o,
  output logic [5:0]                 op,
  output logic [4:0]                 rs,
  output logic [4:0]                 rt,
  output logic [4:0]                 rd,
  output logic [4:0]                 shamt,
  output logic [5:0]                 funct,
  output logic [15:0]                imm,
  output logic [25:0]                target,
`ifdef IR_PC_TRACK_EN
  input  logic [PC_W-1:0]            pc_i,
  output logic [PC_W-1:0]            pc_o,
`endif
  output logic [$clog2(DEPTH+1)-1:0] count
);

  localparam int unsigned PtrW = $clog2(DEPTH);
  localparam int unsigned CntW = $clog2(DEPTH + 1);

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [PtrW-1:0]   wptr_q, wptr_d;
  logic [PtrW-1:0]   rptr_q, rptr_d;
  logic [CntW-1:0]   count_q, count_d;
  logic              push, pop, empty;
  logic [DATA_W-1:0] head;

  assign empty     = (count_q == '0);
  assign in_ready  = (count_q != CntW'(DEPTH));
  assign out_valid = !empty;
  assign push      = in_valid & in_ready;
  assign pop       = out_valid & out_ready;
  assign count     = count_q;

  always_comb begin
    wptr_d  = wptr_q;
    rptr_d  = rptr_q;
    count_d = count_q;
    if (flush) begin
      wptr_d  = '0;
      rptr_d  = '0;
      count_d = '0;
    end else begin
      if (push) wptr_d = wptr_q + PtrW'(1);
      if (pop)  rptr_d = rptr_q + PtrW'(1);
      unique case ({push, pop})
        2'b10:   count_d = count_q + CntW'(1);
        2'b01:   count_d = count_q - CntW'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      wptr_q  <= '0;
      rptr_q  <= '0;
      count_q <= '0;
    end else begin
      wptr_q  <= wptr_d;
      rptr_q  <= rptr_d;
      count_q <= count_d;
    end
  end

  // Storage is deliberately left uncleared by reset.
  always_ff @(posedge clk) begin
    if (push && !flush && !rst) mem_q[wptr_q] <= instr_i;
  end

  assign head    = empty ? '0 : mem_q[rptr_q];
  assign instr_o = head;
  assign op      = head[31:26];
  assign rs      = head[25:21];
  assign rt      = head[20:16];
  assign rd      = head[15:11];
  assign shamt   = head[10:6];
  assign funct   = head[5:0];
  assign imm     = head[15:0];
  assign target  = head[25:0];

`ifdef IR_PC_TRACK_EN
  logic [PC_W-1:0] pc_mem_q [DEPTH];

  always_ff @(posedge clk) begin
    if (push && !flush && !rst) pc_mem_q[wptr_q] <= pc_i;
  end

  assign pc_o = empty ? '0 : pc_mem_q[rptr_q];
`endif

endmodule
